pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 34 +++
 rtl/pc_redirect_buf.sv | 57 +++++
 rtl/pc_gen.sv | 168 ++++++++++++++++
 tb/tb_pc_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg -- shared types and constants for the fetch PC generator.
//
// Contents:
//   pc_state_e       two-state fetch FSM encoding (PC_IDLE, PC_RUN)
//   STOP / NO_STOP   meaning of a stall vector bit
//   BRANCH / NOT_BRANCH  meaning of the branch flag
//   CHIP_ENABLE / CHIP_DISABLE  instruction memory chip-enable levels
//   is_step_aligned  true when an address has its low log2(STEP) bits clear
//
// Optional feature macro used by the importing files: PC_ALIGN_CHECK_EN.
package pc_gen_pkg;

    typedef enum logic {
        PC_IDLE = 1'b0,
        PC_RUN  = 1'b1
    } pc_state_e;

    localparam logic STOP         = 1'b1;
    localparam logic NO_STOP      = 1'b0;
    localparam logic BRANCH       = 1'b1;
    localparam logic NOT_BRANCH   = 1'b0;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    // STEP is a power of two, so STEP-1 is exactly the mask of the bits that
    // must be zero for an address to sit on a fetch boundary.
    function automatic logic is_step_aligned(input logic [63:0] addr,
                                             input int unsigned step);
        logic [63:0] mask;
        mask = 64'(step) - 64'd1;
        return (addr & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf -- holds one deferred branch target and its valid bit.
//
// A branch that arrives while fetch cannot advance is parked here until the
// PC generator is able to apply it.
//
// Ports:
//   clk        input   clock, state updates on posedge
//   rst        input   synchronous reset, active-low
//   capture_i  input   load target_i and set valid (overwrites any held target)
//   clear_i    input   drop the held target
//   target_i   input   [ADDR_W] target to capture
//   valid_o    output  a target is held
//   target_o   output  [ADDR_W] held target (meaningful only when valid_o)
//
// Optional feature macro in this design: PC_ALIGN_CHECK_EN (not used here).
module pc_redirect_buf #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] target_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] target_q, target_d;

    // Capture wins over clear so a fresh branch is never lost; the parent
    // never asserts both in the same cycle anyway.
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (capture_i) begin
            valid_d  = 1'b1;
            target_d = target_i;
        end else if (clear_i) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

    assign valid_o  = valid_q;
    assign target_o = target_q;

endmodule

// File: rtl/pc_gen.sv
// pc_gen -- instruction fetch program counter generator.
//
// Produces the fetch address and instruction memory chip enable. The PC
// advances by STEP when the pipeline is not stalled (stall[0]) and memory
// accepts the address. Redirects, highest priority first: flush, branch,
// deferred branch target, sequential increment, hold. A branch seen while
// fetch cannot advance is parked in pc_redirect_buf and applied on the next
// advancing cycle.
//
// Handshake: the current pc is consumed by instruction memory on a cycle
// where ce=1 and mem_ready=1 and stall[0]=0 ("adv"); the pc changes only on
// adv or on flush (flush does not wait for mem_ready or stall).
//
// Ports:
//   clk                      input   clock, posedge
//   rst                      input   synchronous reset, active-low
//   stall                    input   [STALL_W] stall vector, only bit 0 used
//   mem_ready                input   memory accepts the current pc
//   flush                    input   exception/eret redirect request
//   new_pc                   input   [ADDR_W] flush target
//   branch_flag_i            input   branch taken
//   branch_target_address_i  input   [ADDR_W] branch target
//   pc                       output  [ADDR_W] current fetch address
//   ce                       output  instruction memory chip enable
//   redirect_pending         output  a deferred branch target is held
//   misalign_o               output  one-cycle pulse for a rejected misaligned
//                                    target (only with PC_ALIGN_CHECK_EN)
//   state_o                  output  FSM state, for observation
//
// Optional feature macro: PC_ALIGN_CHECK_EN -- reject flush/branch targets
// whose low log2(STEP) bits are nonzero and report them on misalign_o.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned     STEP         = 4,
    parameter int unsigned     STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               mem_ready,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redirect_pending,
`ifdef PC_ALIGN_CHECK_EN
    output logic               misalign_o,
`endif
    output pc_state_e          state_o
);

    localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic              adv;
    logic              flush_ok;
    logic              branch_ok;
    logic              buf_capture;
    logic              buf_clear;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;

    // Only stall[0] matters to fetch; the rest of the vector belongs to
    // later stages.
    logic unused_stall;
    assign unused_stall = ^stall;

    assign adv = (state_q == PC_RUN) && (stall[0] == NO_STOP) && mem_ready;

`ifdef PC_ALIGN_CHECK_EN
    logic flush_bad;
    logic branch_bad;
    logic misalign_d, misalign_q;

    assign flush_bad  = flush && !is_step_aligned(64'(new_pc), STEP);
    assign branch_bad = (branch_flag_i == BRANCH)
                        && !is_step_aligned(64'(branch_target_address_i), STEP);
    // A rejected target behaves as if the request had not been raised.
    assign flush_ok   = flush && !flush_bad;
    assign branch_ok  = (branch_flag_i == BRANCH) && !branch_bad;
    // A misaligned branch that a good flush overrides is discarded anyway,
    // so it is not reported.
    assign misalign_d = (state_q == PC_RUN) && !flush_ok && (flush_bad || branch_bad);

    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign flush_ok  = flush;
    assign branch_ok = (branch_flag_i == BRANCH);
`endif

    // Next-state and redirect selection. In IDLE every redirect input is
    // ignored and pc keeps RESET_VECTOR, so the first fetch in RUN is the
    // reset vector.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_capture = 1'b0;
        buf_clear   = 1'b0;
        unique case (state_q)
            PC_IDLE: begin
                state_d = PC_RUN;
            end
            PC_RUN: begin
                if (flush_ok) begin
                    pc_d      = new_pc;
                    buf_clear = 1'b1;
                end else if (branch_ok && adv) begin
                    pc_d      = branch_target_address_i;
                    buf_clear = 1'b1;
                end else if (branch_ok) begin
                    buf_capture = 1'b1;
                end else if (pend_valid && adv) begin
                    pc_d      = pend_target;
                    buf_clear = 1'b1;
                end else if (adv) begin
                    // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap.
                    pc_d = pc_q + STEP_INC;
                end
            end
            default: begin
                state_d = PC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= PC_IDLE;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk       (clk),
        .rst       (rst),
        .capture_i (buf_capture),
        .clear_i   (buf_clear),
        .target_i  (branch_target_address_i),
        .valid_o   (pend_valid),
        .target_o  (pend_target)
    );

    assign pc               = pc_q;
    assign ce               = (state_q == PC_RUN) ? CHIP_ENABLE : CHIP_DISABLE;
    assign redirect_pending = pend_valid;
    assign state_o          = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen -- self-checking bench for pc_gen.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam int unsigned ADDR_W  = 32;
  localparam logic [31:0] RV      = 32'h0000_0000;
  localparam int unsigned STEP    = 4;
  localparam int unsigned STALL_W = 6;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               mem_ready;
  logic               flush;
  logic [31:0]        new_pc;
  logic               branch_flag_i;
  logic [31:0]        branch_target_address_i;
  logic [31:0]        pc;
  logic               ce;
  logic               redirect_pending;
  logic               misalign_o;
  pc_state_e          state_o;

`ifndef PC_ALIGN_CHECK_EN
  assign misalign_o = 1'b0;
`endif

  pc_gen #(
    .ADDR_W       (ADDR_W),
    .RESET_VECTOR (RV),
    .STEP         (STEP),
    .STALL_W      (STALL_W)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .mem_ready               (mem_ready),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .pc                      (pc),
    .ce                      (ce),
    .redirect_pending        (redirect_pending),
`ifdef PC_ALIGN_CHECK_EN
    .misalign_o              (misalign_o),
`endif
    .state_o                 (state_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected outputs after each edge: {misalign, running, pending, pc}.
  logic [34:0] exp_q[$];

  bit          m_run = 1'b0;
  logic [31:0] m_pc  = RV;
  bit          m_pv  = 1'b0;
  logic [31:0] m_pt  = '0;
  bit          m_mis = 1'b0;

  function automatic bit misal(input logic [31:0] a);
    return CHK && ((a % STEP) != 0);
  endfunction

  always @(posedge clk) begin
    bit adv, f, b;
    if (rst !== 1'b1) begin
      m_run = 0; m_pc = RV; m_pv = 0; m_pt = '0; m_mis = 0;
    end else if (!m_run) begin
      m_run = 1; m_mis = 0;
    end else begin
      adv   = (stall[0] == 1'b0) && mem_ready;
      f     = flush && !misal(new_pc);
      b     = branch_flag_i && !misal(branch_target_address_i);
      m_mis = !f && ((flush && misal(new_pc)) ||
                     (branch_flag_i && misal(branch_target_address_i)));
      if (f) begin
        m_pc = new_pc; m_pv = 0;
      end else if (b && adv) begin
        m_pc = branch_target_address_i; m_pv = 0;
      end else if (b) begin
        m_pt = branch_target_address_i; m_pv = 1;
      end else if (m_pv && adv) begin
        m_pc = m_pt; m_pv = 0;
      end else if (adv) begin
        m_pc = 32'((longint'(m_pc) + longint'(STEP)) % (longint'(1) << ADDR_W));
      end
    end
    exp_q.push_back({m_mis, m_run, m_pv, m_pc});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [34:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty actual=0 expected=1 at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("sb_pc",      64'(pc), 64'(e[31:0]));
      check("sb_pending", 64'(redirect_pending), 64'(e[32]));
      check("sb_ce",      64'(ce), 64'(e[33]));
      check("sb_state",   64'(state_o), 64'(e[33] ? PC_RUN : PC_IDLE));
      if (CHK) check("sb_misalign", 64'(misalign_o), 64'(e[34]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = '0; mem_ready = 1'b1; flush = 1'b0; new_pc = '0;
    branch_flag_i = 1'b0; branch_target_address_i = '0;
  endtask

  task automatic do_flush(input logic [31:0] t);
    flush = 1'b1; new_pc = t;
    tick();
    flush = 1'b0;
  endtask

  function automatic logic [31:0] rand_target();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
    if (r == 1) return $urandom;
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    idle_inputs();
    // reset held for three edges
    tick(); tick(); tick();
    check("rst_ce",      64'(ce), 64'd0);
    check("rst_pc",      64'(pc), 64'h0);
    check("rst_pending", 64'(redirect_pending), 64'd0);
    rst = 1'b1;
    tick();
    check("first_ce", 64'(ce), 64'd1);
    check("first_pc", 64'(pc), 64'h0);
    tick();
    check("seq_pc4", 64'(pc), 64'h4);
    tick();
    check("seq_pc8", 64'(pc), 64'h8);

    // stall holds pc
    do_flush(32'h100);
    check("flush_100", 64'(pc), 64'h100);
    stall = 6'b000001;
    tick(); tick(); tick();
    check("stall_hold", 64'(pc), 64'h100);
    stall = 6'b111110;  // upper bits must not stall fetch
    tick();
    check("stall_release", 64'(pc), 64'h104);
    stall = '0;

    // branch deferred while memory not ready
    do_flush(32'h200);
    mem_ready = 1'b0;
    branch_flag_i = 1'b1; branch_target_address_i = 32'h400;
    tick();
    branch_flag_i = 1'b0;
    check("defer_pending", 64'(redirect_pending), 64'd1);
    check("defer_hold",    64'(pc), 64'h200);
    tick();
    check("defer_hold2",   64'(pc), 64'h200);
    mem_ready = 1'b1;
    tick();
    check("defer_apply_pc",  64'(pc), 64'h400);
    check("defer_apply_pnd", 64'(redirect_pending), 64'd0);

    // later capture overwrites earlier one
    mem_ready = 1'b0;
    branch_flag_i = 1'b1; branch_target_address_i = 32'h500;
    tick();
    branch_target_address_i = 32'h600;
    tick();
    branch_flag_i = 1'b0; mem_ready = 1'b1;
    tick();
    check("overwrite_pc", 64'(pc), 64'h600);

    // flush beats same-cycle branch and clears pending
    mem_ready = 1'b0;
    branch_flag_i = 1'b1; branch_target_address_i = 32'h700;
    tick();
    mem_ready = 1'b1; stall = 6'b000001;
    flush = 1'b1; new_pc = 32'h180;
    branch_target_address_i = 32'h400;
    tick();
    flush = 1'b0; branch_flag_i = 1'b0;
    check("flush_win_pc",  64'(pc), 64'h180);
    check("flush_win_pnd", 64'(redirect_pending), 64'd0);
    stall = '0;

    // wrap
    do_flush(32'hFFFF_FFFC);
    check("wrap_pre", 64'(pc), 64'hFFFF_FFFC);
    tick();
    check("wrap_pc", 64'(pc), 64'h0);

    // reset mid-operation discards pending target
    mem_ready = 1'b0;
    branch_flag_i = 1'b1; branch_target_address_i = 32'h800;
    tick();
    branch_flag_i = 1'b0;
    rst = 1'b0;
    tick();
    check("midrst_ce",  64'(ce), 64'd0);
    check("midrst_pnd", 64'(redirect_pending), 64'd0);
    rst = 1'b1; mem_ready = 1'b1;
    tick();
    check("midrst_run_pc", 64'(pc), 64'h0);
    tick();
    check("midrst_nocarry", 64'(pc), 64'h4);

`ifdef PC_ALIGN_CHECK_EN
    do_flush(32'h300);
    branch_flag_i = 1'b1; branch_target_address_i = 32'h402;
    tick();
    branch_flag_i = 1'b0;
    check("misal_pc",    64'(pc), 64'h304);
    check("misal_pulse", 64'(misalign_o), 64'd1);
    tick();
    check("misal_clear", 64'(misalign_o), 64'd0);
    check("misal_pc2",   64'(pc), 64'h308);
`endif

    // randomized phase, checked by the scoreboard every cycle
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      stall         = 6'($urandom);
      stall[0]      = ($urandom_range(0, 99) < 30);
      mem_ready     = ($urandom_range(0, 99) < 75);
      flush         = ($urandom_range(0, 99) < 8);
      new_pc        = rand_target();
      branch_flag_i = ($urandom_range(0, 99) < 15);
      branch_target_address_i = rand_target();
      tick();
    end

    idle_inputs();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
